dcache_stage: RTL and testbench

Memory (C) stage of the pipelined processor, fed directly by the A→C pipeline register. It services loads and stores through a direct-mapped, write-back, write-allocate data cache with a blocking miss FSM toward main memory. It registers the stage result into the C→W boundary (W-stage outputs), and asserts `stall` to freeze the upstream stages while a miss is in flight.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_stage_if.sv | 30 +++
 rtl/dcache_array.sv | 65 ++++++
 rtl/dcache_stage.sv | 184 ++++++++++++++++++
 tb/tb_dcache_stage.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the C-stage data cache: FSM states, access
// encodings and the default line/index/tag split.
package dcache_pkg;

  localparam int DC_DATA_WIDTH = 32;
  localparam int DC_LINES      = 4;
  localparam int DC_LINE_BYTES = 16;

  localparam int DC_OFFSET_W = $clog2(DC_LINE_BYTES);
  localparam int DC_INDEX_W  = $clog2(DC_LINES);
  localparam int DC_TAG_W    = DC_DATA_WIDTH - DC_OFFSET_W - DC_INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } dc_state_t;

  // C_DC_rd_wr encodings; 2'b11 is deliberately absent and behaves as NONE
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/dcache_stage_if.sv
// Line-granular memory port between the data cache and main memory.
interface dcache_stage_if
  import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int LINE_BYTES = DC_LINE_BYTES
);

  // Handshake: the cache raises mem_req with mem_we/mem_addr/mem_wdata and holds
  // all four stable until the edge where mem_ack (a one-cycle pulse) is seen;
  // mem_rdata is only meaningful in the mem_ack cycle; mem_ack without mem_req
  // carries no meaning and is ignored.
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [LINE_BYTES*8-1:0] mem_wdata;
  logic [LINE_BYTES*8-1:0] mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port and one
// synchronous write port that either merges store bytes or installs a whole line.
module dcache_array
  import dcache_pkg::*;
#(
    parameter int LINES      = DC_LINES,
    parameter int LINE_BYTES = DC_LINE_BYTES,
    parameter int TAG_W      = DC_TAG_W,
    localparam int INDEX_W   = $clog2(LINES),
    localparam int LINE_W    = LINE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  wr_en,
    input  logic                  wr_fill,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_W-1:0]     wr_data
);

    logic [LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    // Payload storage carries no reset; valid bits guard every use of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_fill || wr_be[b]) begin
                    data_q[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
            if (wr_fill) begin
                tag_q[wr_index] <= wr_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            if (wr_fill) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end else begin
                dirty_q[wr_index] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_stage.sv
// Memory (C) stage: direct-mapped write-back/write-allocate data cache with a
// blocking miss FSM, registering its result into the C->W boundary.
module dcache_stage
  import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int LINES      = DC_LINES,
    parameter int LINE_BYTES = DC_LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] C_w,
    input  logic [DATA_WIDTH-1:0] C_sdata,
    input  logic [6:0]            C_regDst,
    input  logic [1:0]            C_DC_rd_wr,
    input  logic                  C_DC_we,
    input  logic                  C_MuxD,
    input  logic                  C_RF_wrd,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] W_data,
    output logic [6:0]            W_regDst,
    output logic                  W_RF_wrd,
    dcache_stage_if.master        mem,
    output dc_state_t             dbg_state
);

    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int INDEX_W    = $clog2(LINES);
    localparam int TAG_W      = DATA_WIDTH - OFFSET_W - INDEX_W;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int WORDS      = LINE_BYTES / WORD_BYTES;
    localparam logic [LINE_BYTES-1:0] WORD_BE =
        {{(LINE_BYTES-WORD_BYTES){1'b0}}, {WORD_BYTES{1'b1}}};
    localparam logic [LINE_BYTES-1:0] BYTE_BE = {{(LINE_BYTES-1){1'b0}}, 1'b1};

    dc_state_t state;

    logic [OFFSET_W-1:0] c_offset;
    logic [OFFSET_W-1:0] c_word_off;
    logic [INDEX_W-1:0]  c_index;
    logic [TAG_W-1:0]    c_tag;

    logic              arr_valid;
    logic              arr_dirty;
    logic [TAG_W-1:0]  arr_tag;
    logic [LINE_W-1:0] arr_line;

    logic is_load, is_store, is_mem, hit, miss;
    logic store_wr, fill_wr, ack_seen;

    logic [LINE_W-1:0]     word_shifted;
    logic [LINE_W-1:0]     byte_shifted;
    logic [DATA_WIDTH-1:0] load_data;
    logic [LINE_BYTES-1:0] st_be;
    logic [LINE_W-1:0]     st_data;
    logic [LINE_W-1:0]     wr_data;
    logic [DATA_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] wb_addr;

    logic                  req_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [LINE_W-1:0]     wdata_q;

    assign c_offset   = C_w[OFFSET_W-1:0];
    assign c_word_off = c_offset & ~OFFSET_W'(WORD_BYTES - 1);
    assign c_index    = C_w[OFFSET_W +: INDEX_W];
    assign c_tag      = C_w[DATA_WIDTH-1 -: TAG_W];

    assign is_load  = (C_DC_rd_wr == OP_LOAD);
    assign is_store = (C_DC_rd_wr == OP_STORE);
    assign is_mem   = is_load || is_store;
    assign hit      = arr_valid && (arr_tag == c_tag);
    assign miss     = is_mem && !hit;

    // While a miss is in flight the upstream inputs are frozen, so the same
    // access is simply looked up again once the FSM returns to IDLE.
    assign stall = (state != IDLE) || miss;

    assign word_shifted = arr_line >> {c_word_off, 3'b000};
    assign byte_shifted = arr_line >> {c_offset, 3'b000};
    assign load_data = (C_DC_we == SIZE_BYTE)
        ? {{(DATA_WIDTH-8){byte_shifted[7]}}, byte_shifted[7:0]}
        : word_shifted[DATA_WIDTH-1:0];

    assign st_be   = (C_DC_we == SIZE_WORD) ? (WORD_BE << c_word_off) : (BYTE_BE << c_offset);
    assign st_data = (C_DC_we == SIZE_WORD) ? {WORDS{C_sdata}} : {LINE_BYTES{C_sdata[7:0]}};

    assign ack_seen = req_q && mem.mem_ack;
    assign store_wr = (state == IDLE) && is_store && hit;
    assign fill_wr  = (state == FILL) && ack_seen;
    assign wr_data  = fill_wr ? mem.mem_rdata : st_data;

    assign fill_addr = {c_tag, c_index, {OFFSET_W{1'b0}}};
    assign wb_addr   = {arr_tag, c_index, {OFFSET_W{1'b0}}};

    dcache_array #(
        .LINES      (LINES),
        .LINE_BYTES (LINE_BYTES),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (c_index),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .wr_en    ((store_wr || fill_wr) && !reset),
        .wr_fill  (fill_wr),
        .wr_index (c_index),
        .wr_tag   (c_tag),
        .wr_be    (st_be),
        .wr_data  (wr_data)
    );

    // Reset outranks a same-cycle mem_ack, abandoning any open transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        req_q <= 1'b1;
                        if (arr_valid && arr_dirty) begin
                            state   <= WB;
                            we_q    <= 1'b1;
                            addr_q  <= wb_addr;
                            wdata_q <= arr_line;
                        end else begin
                            state  <= FILL;
                            we_q   <= 1'b0;
                            addr_q <= fill_addr;
                        end
                    end
                end
                WB: begin
                    if (ack_seen) begin
                        state  <= FILL;
                        we_q   <= 1'b0;
                        addr_q <= fill_addr;
                    end
                end
                FILL: begin
                    if (ack_seen) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            W_data   <= '0;
            W_regDst <= '0;
            W_RF_wrd <= 1'b0;
        end else if (stall) begin
            W_RF_wrd <= 1'b0;
        end else begin
            W_data   <= C_MuxD ? load_data : C_w;
            W_regDst <= C_regDst;
            W_RF_wrd <= C_RF_wrd;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_dcache_stage.sv
// Directed + randomized bench for dcache_stage with an architectural memory
// model, a line-level memory responder and a W-stage scoreboard.
module tb_dcache_stage;
  import dcache_pkg::*;

  localparam int STALL_LIMIT = 64;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         chk_wdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic [31:0] C_w;
  logic [31:0] C_sdata;
  logic [6:0]  C_regDst;
  logic [1:0]  C_DC_rd_wr;
  logic        C_DC_we;
  logic        C_MuxD;
  logic        C_RF_wrd;
  logic        stall;
  logic [31:0] W_data;
  logic [6:0]  W_regDst;
  logic        W_RF_wrd;
  dc_state_t   dbg_state;

  dcache_stage_if #(.DATA_WIDTH(32), .LINE_BYTES(16)) mem_bus ();

  dcache_stage #(.DATA_WIDTH(32), .LINES(4), .LINE_BYTES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .C_w        (C_w),
    .C_sdata    (C_sdata),
    .C_regDst   (C_regDst),
    .C_DC_rd_wr (C_DC_rd_wr),
    .C_DC_we    (C_DC_we),
    .C_MuxD     (C_MuxD),
    .C_RF_wrd   (C_RF_wrd),
    .stall      (stall),
    .W_data     (W_data),
    .W_regDst   (W_regDst),
    .W_RF_wrd   (W_RF_wrd),
    .mem        (mem_bus),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [6:0]  exp_rd_q[$];
  logic        exp_wrd_q[$];
  txn_t        exp_txn_q[$];
  txn_t        act_q[$];

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] back_mem [logic [31:0]];

  logic stall_at_issue;
  logic first_req;
  logic req_any;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- models ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] al = {a[31:2], 2'b00};
    if (ref_mem.exists(al)) return ref_mem[al];
    return init_word(al);
  endfunction

  function automatic logic [31:0] back_word(input logic [31:0] a);
    if (back_mem.exists(a)) return back_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] base);
    logic [127:0] line;
    for (int w = 0; w < 4; w++) line[w*32 +: 32] = ref_word(base + 32'(4 * w));
    return line;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic word);
    logic [31:0] w = ref_word(a);
    logic [31:0] b = w >> (8 * a[1:0]);
    if (word) return w;
    return {{24{b[7]}}, b[7:0]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic word, input logic [31:0] d);
    logic [31:0] w = ref_word(a);
    if (word) w = d;
    else w[a[1:0]*8 +: 8] = d[7:0];
    ref_mem[{a[31:2], 2'b00}] = w;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int cnt;
    int lat;
    logic [127:0] line;
    logic [31:0] base;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    cnt = 0;
    lat = 2;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_bus.mem_req) begin
        if (cnt == 0) lat = $urandom_range(1, 3);
        cnt++;
        if (cnt >= lat) begin
          base = mem_bus.mem_addr;
          act_q.push_back('{we: mem_bus.mem_we, addr: base, wdata: mem_bus.mem_wdata, chk_wdata: 1'b0});
          if (mem_bus.mem_we) begin
            for (int w = 0; w < 4; w++) back_mem[base + 32'(4 * w)] = mem_bus.mem_wdata[w*32 +: 32];
          end else begin
            for (int w = 0; w < 4; w++) line[w*32 +: 32] = back_word(base + 32'(4 * w));
            mem_bus.mem_rdata = line;
          end
          mem_bus.mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input logic we, input logic [31:0] addr,
                          input logic [127:0] wdata, input logic chk);
    exp_txn_q.push_back('{we: we, addr: addr, wdata: wdata, chk_wdata: chk});
  endtask

  task automatic check_txns();
    txn_t e;
    txn_t a;
    check("txn_count", 128'(act_q.size()), 128'(exp_txn_q.size()));
    while (exp_txn_q.size() > 0 && act_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = act_q.pop_front();
      check("txn_we", a.we, e.we);
      check("txn_addr", a.addr, e.addr);
      if (e.chk_wdata) check("txn_wdata", a.wdata, e.wdata);
    end
    exp_txn_q.delete();
    act_q.delete();
  endtask

  task automatic issue(input logic [1:0] rw, input logic word, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [6:0] rd,
                       input logic muxd, input logic rfw);
    int cyc;
    exp_q.push_back(muxd ? exp_load(addr, word) : addr);
    exp_rd_q.push_back(rd);
    exp_wrd_q.push_back(rfw);
    if (rw == OP_STORE) ref_store(addr, word, sdata);
    @(negedge clk);
    C_w = addr; C_sdata = sdata; C_regDst = rd; C_DC_rd_wr = rw;
    C_DC_we = word; C_MuxD = muxd; C_RF_wrd = rfw;
    #1;
    stall_at_issue = stall;
    first_req = 1'b0;
    req_any = mem_bus.mem_req;
    cyc = 0;
    while (stall && cyc < STALL_LIMIT) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (cyc == 0) first_req = mem_bus.mem_req;
      req_any |= mem_bus.mem_req;
      check("bubble_wrd", W_RF_wrd, 1'b0);
      cyc++;
    end
    check("stall_release", stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    req_any |= mem_bus.mem_req;
    check("w_data", W_data, exp_q.pop_front());
    check("w_regdst", W_regDst, exp_rd_q.pop_front());
    check("w_rf_wrd", W_RF_wrd, exp_wrd_q.pop_front());
    C_DC_rd_wr = OP_NONE;
    C_RF_wrd = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] wb_line;
    int cyc;

    reset = 1'b1;
    C_w = '0; C_sdata = '0; C_regDst = '0; C_DC_rd_wr = OP_NONE;
    C_DC_we = 1'b1; C_MuxD = 1'b0; C_RF_wrd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_w_data", W_data, 32'h0);
    check("rst_w_regdst", W_regDst, 7'h0);
    check("rst_w_rf_wrd", W_RF_wrd, 1'b0);
    check("rst_mem_req", mem_bus.mem_req, 1'b0);
    check("rst_mem_we", mem_bus.mem_we, 1'b0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_state", dbg_state, IDLE);
    check("rst_stall", stall, 1'b0);
    reset = 1'b0;

    // cold word load: clean miss, fill from 0x40
    push_txn(1'b0, 32'h40, '0, 1'b0);
    issue(OP_LOAD, 1'b1, 32'h40, 32'h0, 7'd5, 1'b1, 1'b1);
    check("cold_stall", stall_at_issue, 1'b1);
    check("cold_req_first_edge", first_req, 1'b1);
    check_txns();
    @(negedge clk);
    #1;
    check("cold_wrd_once", W_RF_wrd, 1'b0);

    // store hit, then sign-extended byte loads of the stored word
    issue(OP_STORE, 1'b1, 32'h44, 32'hDEADBEEF, 7'd0, 1'b0, 1'b0);
    check("st_hit_nostall", stall_at_issue, 1'b0);
    issue(OP_LOAD, 1'b0, 32'h47, 32'h0, 7'd6, 1'b1, 1'b1);
    issue(OP_LOAD, 1'b0, 32'h45, 32'h0, 7'd7, 1'b1, 1'b1);
    issue(OP_LOAD, 1'b0, 32'h44, 32'h0, 7'd8, 1'b1, 1'b1);
    issue(OP_STORE, 1'b0, 32'h49, 32'h0000005A, 7'd0, 1'b0, 1'b0);
    issue(OP_LOAD, 1'b1, 32'h4B, 32'h0, 7'd9, 1'b1, 1'b1);
    check_txns();

    // non-memory ops, including the 11 encoding at a missing address
    issue(OP_NONE, 1'b1, 32'h1234, 32'h0, 7'd3, 1'b0, 1'b1);
    check("nonmem_nostall", stall_at_issue, 1'b0);
    check("nonmem_noreq", req_any, 1'b0);
    issue(2'b11, 1'b1, 32'h104, 32'h0, 7'd4, 1'b0, 1'b1);
    check("op11_nostall", stall_at_issue, 1'b0);
    check("op11_noreq", req_any, 1'b0);

    // dirty conflict miss: write back 0x40, then fill 0x100
    wb_line = ref_line(32'h40);
    push_txn(1'b1, 32'h40, wb_line, 1'b1);
    push_txn(1'b0, 32'h100, '0, 1'b0);
    issue(OP_LOAD, 1'b1, 32'h104, 32'h0, 7'd10, 1'b1, 1'b1);
    if (act_q.size() > 0) check("wb_bytes4_7", act_q[0].wdata[63:32], 32'hDEADBEEF);
    check_txns();

    // victim 0x100 is clean: refill 0x40 straight from memory
    push_txn(1'b0, 32'h40, '0, 1'b0);
    issue(OP_LOAD, 1'b1, 32'h44, 32'h0, 7'd11, 1'b1, 1'b1);
    check_txns();

    // reset lands on the same edge as the fill acknowledge
    push_txn(1'b0, 32'h300, '0, 1'b0);
    push_txn(1'b0, 32'h300, '0, 1'b0);
    @(negedge clk);
    C_w = 32'h300; C_DC_rd_wr = OP_LOAD; C_DC_we = 1'b1;
    C_MuxD = 1'b1; C_RF_wrd = 1'b1; C_regDst = 7'd12;
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      #1;
      cyc++;
    end while (!mem_bus.mem_ack && cyc < STALL_LIMIT);
    check("rst_ack_seen", mem_bus.mem_ack, 1'b1);
    check("rst_ack_in_fill", dbg_state, FILL);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_abort_req", mem_bus.mem_req, 1'b0);
    check("rst_abort_state", dbg_state, IDLE);
    check("rst_abort_wrd", W_RF_wrd, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_remiss", stall, 1'b1);
    C_DC_rd_wr = OP_NONE;
    C_RF_wrd = 1'b0;
    issue(OP_LOAD, 1'b1, 32'h300, 32'h0, 7'd12, 1'b1, 1'b1);
    check("rst_reload_stall", stall_at_issue, 1'b1);
    check_txns();

    // randomized loads/stores over a few conflicting lines
    for (int i = 0; i < 40; i++) begin
      logic is_ld;
      is_ld = 1'($urandom_range(0, 1));
      issue(is_ld ? OP_LOAD : OP_STORE, 1'($urandom_range(0, 1)),
            32'h800 + 32'($urandom_range(0, 255)), $urandom(),
            7'($urandom_range(0, 127)), is_ld, 1'($urandom_range(0, 1)));
    end
    act_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
